video_mnist_cnn_flush_ctrl: RTL and testbench

Frame scheduler placed in front of the three-stage MNIST detection CNN core. It admits whole video frames from the source AXI4-Stream, forwards them into the core, and then injects `param_blank_num` zero-data blanking lines so the core's line buffers drain the last frame's results. It also reports busy, frame-count and framing-error status to software.

---
 rtl/video_mnist_cnn_flush_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_video_mnist_cnn_flush_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mnist_cnn_flush_ctrl.sv
// Frame scheduler in front of the MNIST detection CNN core.
// Admits whole frames from the source stream, forwards them through a single
// output register, then injects zero-data blanking lines so the core's line
// buffers drain the last frame's results.
module video_mnist_cnn_flush_ctrl #(
  parameter int TUSER_WIDTH   = 1,
  parameter int TDATA_WIDTH   = 1,
  parameter int IMG_X_WIDTH   = 11,
  parameter int IMG_Y_WIDTH   = 10,
  parameter int BLANK_Y_WIDTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     ctl_enable,
  input  logic [IMG_X_WIDTH-1:0]   param_width,
  input  logic [IMG_Y_WIDTH-1:0]   param_height,
  input  logic [BLANK_Y_WIDTH-1:0] param_blank_num,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready,
  output logic                     status_busy,
  output logic [31:0]              status_frame_count,
  output logic                     status_error
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_PASS,
    ST_FLUSH
  } state_t;

  state_t state, state_next;

  logic [IMG_X_WIDTH-1:0]   x_cnt, x_next, width_reg, width_next;
  logic [IMG_Y_WIDTH-1:0]   y_cnt, y_next, height_reg, height_next;
  logic [BLANK_Y_WIDTH-1:0] bline_cnt, bline_next, blank_reg, blank_next;

  logic [TUSER_WIDTH-1:0]   tuser_next;
  logic                     tlast_next;
  logic [TDATA_WIDTH-1:0]   tdata_next;
  logic                     tvalid_next;
  logic [31:0]              count_next;
  logic                     error_next;

  logic                     ld;
  logic                     take;
  logic                     frame_done;
  logic                     flush_last;
  logic [IMG_X_WIDTH-1:0]   cur_x, x_inc, eff_w;
  logic [IMG_Y_WIDTH-1:0]   cur_y, eff_h;
  logic [BLANK_Y_WIDTH-1:0] eff_b;

  // The output register can accept a new beat when empty or being drained.
  assign ld = !m_axi4s_tvalid || m_axi4s_tready;

  assign status_busy = (state != ST_IDLE);

  // Next-state, counter, output-register and source-ready decode.
  always_comb begin
    state_next     = state;
    x_next         = x_cnt;
    y_next         = y_cnt;
    bline_next     = bline_cnt;
    width_next     = width_reg;
    height_next    = height_reg;
    blank_next     = blank_reg;
    tuser_next     = m_axi4s_tuser;
    tlast_next     = m_axi4s_tlast;
    tdata_next     = m_axi4s_tdata;
    tvalid_next    = m_axi4s_tvalid && !m_axi4s_tready;
    count_next     = status_frame_count;
    error_next     = 1'b0;
    s_axi4s_tready = 1'b0;
    take           = 1'b0;
    frame_done     = 1'b0;
    flush_last     = 1'b0;
    cur_x          = x_cnt;
    cur_y          = y_cnt;
    x_inc          = '0;
    eff_w          = width_reg;
    eff_h          = height_reg;
    eff_b          = blank_reg;

    case (state)
      ST_IDLE: begin
        if (ctl_enable) state_next = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        // Ready only while the output register has room, so an arriving SOF
        // beat always has a slot to land in; non-SOF beats are simply dropped.
        s_axi4s_tready = ld;
        if (s_axi4s_tvalid && ld) begin
          if (s_axi4s_tuser[0]) take = 1'b1;
        end else if (!ctl_enable) begin
          state_next = ST_IDLE;
        end
      end
      ST_PASS: begin
        s_axi4s_tready = ld;
        if (s_axi4s_tvalid && ld) take = 1'b1;
      end
      ST_FLUSH: begin
        if (ld) begin
          flush_last  = (x_cnt == width_reg - IMG_X_WIDTH'(1));
          tvalid_next = 1'b1;
          tuser_next  = '0;
          tdata_next  = '0;
          tlast_next  = flush_last;
          if (flush_last) begin
            x_next = '0;
            if (bline_cnt == blank_reg - BLANK_Y_WIDTH'(1)) frame_done = 1'b1;
            else bline_next = bline_cnt + BLANK_Y_WIDTH'(1);
          end else begin
            x_next = x_cnt + IMG_X_WIDTH'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A SOF beat (first or resync) restarts the frame with fresh parameters
    // before the ordinary per-beat accounting, so width-1 SOF lines also work.
    if (take) begin
      tvalid_next = 1'b1;
      tuser_next  = s_axi4s_tuser;
      tlast_next  = s_axi4s_tlast;
      tdata_next  = s_axi4s_tdata;
      state_next  = ST_PASS;
      if (s_axi4s_tuser[0]) begin
        width_next  = param_width;
        height_next = param_height;
        blank_next  = param_blank_num;
        eff_w       = param_width;
        eff_h       = param_height;
        eff_b       = param_blank_num;
        cur_x       = '0;
        cur_y       = '0;
        if (state == ST_PASS) error_next = 1'b1;
      end
      x_inc  = cur_x + IMG_X_WIDTH'(1);
      y_next = cur_y;
      if (s_axi4s_tlast) begin
        if (x_inc != eff_w) error_next = 1'b1;
        x_next = '0;
        if (cur_y == eff_h - IMG_Y_WIDTH'(1)) begin
          y_next = '0;
          if (eff_b != '0) begin
            state_next = ST_FLUSH;
            bline_next = '0;
          end else begin
            frame_done = 1'b1;
          end
        end else begin
          y_next = cur_y + IMG_Y_WIDTH'(1);
        end
      end else begin
        x_next = x_inc;
      end
    end

    if (frame_done) begin
      count_next = status_frame_count + 32'd1;
      x_next     = '0;
      y_next     = '0;
      bline_next = '0;
      state_next = ctl_enable ? ST_WAIT_SOF : ST_IDLE;
    end
  end

  // State, counters, latched parameters, output register and status flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state              <= ST_IDLE;
      x_cnt              <= '0;
      y_cnt              <= '0;
      bline_cnt          <= '0;
      width_reg          <= '0;
      height_reg         <= '0;
      blank_reg          <= '0;
      m_axi4s_tuser      <= '0;
      m_axi4s_tlast      <= 1'b0;
      m_axi4s_tdata      <= '0;
      m_axi4s_tvalid     <= 1'b0;
      status_frame_count <= '0;
      status_error       <= 1'b0;
    end else begin
      state              <= state_next;
      x_cnt              <= x_next;
      y_cnt              <= y_next;
      bline_cnt          <= bline_next;
      width_reg          <= width_next;
      height_reg         <= height_next;
      blank_reg          <= blank_next;
      m_axi4s_tuser      <= tuser_next;
      m_axi4s_tlast      <= tlast_next;
      m_axi4s_tdata      <= tdata_next;
      m_axi4s_tvalid     <= tvalid_next;
      status_frame_count <= count_next;
      status_error       <= error_next;
    end
  end

endmodule

// File: tb/tb_video_mnist_cnn_flush_ctrl.sv
// Bench for video_mnist_cnn_flush_ctrl: a table of frame scenarios plus
// hand-written error, enable-drop and reset-in-flush sequences, with every
// output beat matched against a queue of expected beats.
module tb_video_mnist_cnn_flush_ctrl;

  logic        aclk;
  logic        aresetn;
  logic        ctl_enable;
  logic [10:0] param_width;
  logic [9:0]  param_height;
  logic [7:0]  param_blank_num;
  logic [0:0]  s_axi4s_tuser;
  logic        s_axi4s_tlast;
  logic [7:0]  s_axi4s_tdata;
  logic        s_axi4s_tvalid;
  logic        s_axi4s_tready;
  logic [0:0]  m_axi4s_tuser;
  logic        m_axi4s_tlast;
  logic [7:0]  m_axi4s_tdata;
  logic        m_axi4s_tvalid;
  logic        m_axi4s_tready;
  logic        status_busy;
  logic [31:0] status_frame_count;
  logic        status_error;

  typedef struct packed {
    logic       tuser;
    logic       tlast;
    logic [7:0] tdata;
  } beat_t;

  typedef struct {
    int width;
    int height;
    int blank;
    bit rand_ready;
    int frames;
    int pre_junk;
  } vec_t;

  beat_t       exp_q[$];
  vec_t        vecs[6];
  int          checks;
  int          errors;
  int          err_seen;
  int          err_base;
  int          exp_count;
  bit          rand_mode;
  logic [7:0]  data_seq;
  logic        stalled;
  logic [10:0] stall_val;

  video_mnist_cnn_flush_ctrl #(
    .TUSER_WIDTH  (1),
    .TDATA_WIDTH  (8),
    .IMG_X_WIDTH  (11),
    .IMG_Y_WIDTH  (10),
    .BLANK_Y_WIDTH(8)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .ctl_enable        (ctl_enable),
    .param_width       (param_width),
    .param_height      (param_height),
    .param_blank_num   (param_blank_num),
    .s_axi4s_tuser     (s_axi4s_tuser),
    .s_axi4s_tlast     (s_axi4s_tlast),
    .s_axi4s_tdata     (s_axi4s_tdata),
    .s_axi4s_tvalid    (s_axi4s_tvalid),
    .s_axi4s_tready    (s_axi4s_tready),
    .m_axi4s_tuser     (m_axi4s_tuser),
    .m_axi4s_tlast     (m_axi4s_tlast),
    .m_axi4s_tdata     (m_axi4s_tdata),
    .m_axi4s_tvalid    (m_axi4s_tvalid),
    .m_axi4s_tready    (m_axi4s_tready),
    .status_busy       (status_busy),
    .status_frame_count(status_frame_count),
    .status_error      (status_error)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offers one source beat and holds it until the DUT accepts it.
  task automatic applyStimulus(input logic u, input logic l, input logic [7:0] d);
    int   n;
    logic hs;
    s_axi4s_tuser  = u;
    s_axi4s_tlast  = l;
    s_axi4s_tdata  = d;
    s_axi4s_tvalid = 1'b1;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 200) begin
      @(negedge aclk);
      hs = s_axi4s_tready;
      @(posedge aclk);
      #1;
      n++;
    end
    checkOutput("stim_accept", 32'(hs), 32'd1);
    s_axi4s_tvalid = 1'b0;
    s_axi4s_tuser  = '0;
    s_axi4s_tlast  = 1'b0;
  endtask

  task automatic drive_beat(input logic u, input logic l);
    beat_t b;
    data_seq = data_seq + 8'd1;
    b.tuser = u;
    b.tlast = l;
    b.tdata = data_seq;
    exp_q.push_back(b);
    applyStimulus(u, l, data_seq);
  endtask

  task automatic push_flush(input int w, input int nb);
    beat_t b;
    for (int ln = 0; ln < nb; ln++) begin
      for (int px = 0; px < w; px++) begin
        b.tuser = 1'b0;
        b.tlast = (px == w - 1);
        b.tdata = 8'd0;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic send_frame(input int w, input int h, input int nb);
    for (int ln = 0; ln < h; ln++) begin
      for (int px = 0; px < w; px++) begin
        drive_beat((ln == 0 && px == 0), (px == w - 1));
      end
    end
    push_flush(w, nb);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge aclk);
      n++;
    end
    checkOutput("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic set_params(input int w, input int h, input int nb);
    param_width     = 11'(w);
    param_height    = 10'(h);
    param_blank_num = 8'(nb);
  endtask

  // Sink ready: held high or toggled randomly each cycle.
  initial begin
    m_axi4s_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axi4s_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pops, stall stability and error-pulse count.
  initial begin
    beat_t e;
    stalled   = 1'b0;
    stall_val = '0;
    err_seen  = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stalled = 1'b0;
      end else begin
        if (stalled)
          checkOutput("stall_hold", {21'd0, m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata},
                      {21'd0, stall_val});
        if (m_axi4s_tvalid && m_axi4s_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_extra: got %0h, expected no beat at %0t",
                     {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}, $time);
          end else begin
            e = exp_q.pop_front();
            checkOutput("beat", {22'd0, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}, {22'd0, e});
          end
        end
        stalled   = m_axi4s_tvalid && !m_axi4s_tready;
        stall_val = {m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata};
        if (status_error) err_seen++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks          = 0;
    errors          = 0;
    exp_count       = 0;
    rand_mode       = 1'b0;
    data_seq        = 8'd0;
    aresetn         = 1'b1;
    ctl_enable      = 1'b0;
    s_axi4s_tuser   = '0;
    s_axi4s_tlast   = 1'b0;
    s_axi4s_tdata   = '0;
    s_axi4s_tvalid  = 1'b0;
    set_params(4, 3, 2);

    vecs[0] = '{width: 4, height: 3, blank: 2, rand_ready: 1'b0, frames: 1, pre_junk: 0};
    vecs[1] = '{width: 4, height: 3, blank: 2, rand_ready: 1'b1, frames: 1, pre_junk: 0};
    vecs[2] = '{width: 4, height: 3, blank: 0, rand_ready: 1'b0, frames: 2, pre_junk: 0};
    vecs[3] = '{width: 4, height: 3, blank: 2, rand_ready: 1'b0, frames: 1, pre_junk: 5};
    vecs[4] = '{width: 1, height: 2, blank: 1, rand_ready: 1'b1, frames: 1, pre_junk: 0};
    vecs[5] = '{width: 3, height: 1, blank: 3, rand_ready: 1'b1, frames: 2, pre_junk: 2};

    #2 aresetn = 1'b0;
    #20;
    checkOutput("rst_m_tvalid", 32'(m_axi4s_tvalid), 32'd0);
    checkOutput("rst_m_tdata", 32'(m_axi4s_tdata), 32'd0);
    checkOutput("rst_m_tuser", 32'(m_axi4s_tuser), 32'd0);
    checkOutput("rst_m_tlast", 32'(m_axi4s_tlast), 32'd0);
    checkOutput("rst_s_tready", 32'(s_axi4s_tready), 32'd0);
    checkOutput("rst_busy", 32'(status_busy), 32'd0);
    checkOutput("rst_count", status_frame_count, 32'd0);
    checkOutput("rst_error", 32'(status_error), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    checkOutput("idle_busy", 32'(status_busy), 32'd0);
    ctl_enable = 1'b1;

    for (int i = 0; i < 6; i++) begin
      $display("[TB] scenario %0d: w=%0d h=%0d blank=%0d", i, vecs[i].width, vecs[i].height, vecs[i].blank);
      err_base  = err_seen;
      rand_mode = vecs[i].rand_ready;
      set_params(vecs[i].width, vecs[i].height, vecs[i].blank);
      for (int j = 0; j < vecs[i].pre_junk; j++) begin
        data_seq = data_seq + 8'd1;
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), data_seq);
      end
      for (int f = 0; f < vecs[i].frames; f++)
        send_frame(vecs[i].width, vecs[i].height, vecs[i].blank);
      exp_count += vecs[i].frames;
      wait_drain();
      checkOutput("frame_count", status_frame_count, 32'(exp_count));
      checkOutput("wait_sof_busy", 32'(status_busy), 32'd1);
      checkOutput("wait_sof_ready", 32'(s_axi4s_tready), 32'd1);
      checkOutput("no_error", 32'(err_seen - err_base), 32'd0);
    end

    // Early tlast, then a mid-frame SOF that resyncs onto a new frame.
    $display("[TB] sequence: early tlast and mid-frame SOF");
    rand_mode = 1'b0;
    err_base  = err_seen;
    set_params(4, 3, 1);
    drive_beat(1'b1, 1'b0);
    drive_beat(1'b0, 1'b0);
    drive_beat(1'b0, 1'b1);
    checkOutput("early_tlast_err", 32'(status_error), 32'd1);
    drive_beat(1'b0, 1'b0);
    checkOutput("err_one_cycle", 32'(status_error), 32'd0);
    drive_beat(1'b0, 1'b0);
    drive_beat(1'b1, 1'b0);
    checkOutput("mid_sof_err", 32'(status_error), 32'd1);
    checkOutput("count_after_resync", status_frame_count, 32'(exp_count));
    drive_beat(1'b0, 1'b0);
    drive_beat(1'b0, 1'b0);
    drive_beat(1'b0, 1'b1);
    for (int ln = 0; ln < 2; ln++) begin
      for (int px = 0; px < 4; px++) drive_beat(1'b0, (px == 3));
    end
    push_flush(4, 1);
    exp_count++;
    wait_drain();
    checkOutput("resync_count", status_frame_count, 32'(exp_count));
    checkOutput("err_pulses", 32'(err_seen - err_base), 32'd2);

    // Enable dropped in the second line: frame and flush still complete.
    $display("[TB] sequence: ctl_enable dropped mid-frame");
    rand_mode = 1'b1;
    set_params(4, 3, 2);
    for (int px = 0; px < 4; px++) drive_beat((px == 0), (px == 3));
    drive_beat(1'b0, 1'b0);
    ctl_enable = 1'b0;
    drive_beat(1'b0, 1'b0);
    drive_beat(1'b0, 1'b0);
    drive_beat(1'b0, 1'b1);
    for (int px = 0; px < 4; px++) drive_beat(1'b0, (px == 3));
    push_flush(4, 2);
    exp_count++;
    wait_drain();
    checkOutput("disable_count", status_frame_count, 32'(exp_count));
    checkOutput("disable_busy", 32'(status_busy), 32'd0);
    checkOutput("disable_ready", 32'(s_axi4s_tready), 32'd0);

    // Reset pulsed while blanking lines are being emitted.
    $display("[TB] sequence: reset during flush");
    rand_mode  = 1'b0;
    ctl_enable = 1'b1;
    set_params(4, 2, 3);
    send_frame(4, 2, 3);
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("flush_valid", 32'(m_axi4s_tvalid), 32'd1);
    checkOutput("flush_data", 32'(m_axi4s_tdata), 32'd0);
    checkOutput("flush_busy", 32'(status_busy), 32'd1);
    aresetn = 1'b0;
    #1;
    checkOutput("rst2_m_tvalid", 32'(m_axi4s_tvalid), 32'd0);
    checkOutput("rst2_m_tlast", 32'(m_axi4s_tlast), 32'd0);
    checkOutput("rst2_m_tuser", 32'(m_axi4s_tuser), 32'd0);
    checkOutput("rst2_s_tready", 32'(s_axi4s_tready), 32'd0);
    checkOutput("rst2_busy", 32'(status_busy), 32'd0);
    checkOutput("rst2_count", status_frame_count, 32'd0);
    checkOutput("rst2_error", 32'(status_error), 32'd0);
    exp_q.delete();
    exp_count = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    set_params(4, 3, 2);
    send_frame(4, 3, 2);
    exp_count++;
    wait_drain();
    checkOutput("post_rst_count", status_frame_count, 32'(exp_count));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
